// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch and
// MEM-stage data accesses; data wins ties, a streak counter keeps fetch alive.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_dmtype,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_dmtype,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] streak_reg;
  logic [TW-1:0] timer_reg;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [2:0]    dmtype_reg;
  logic [31:0]   if_rdata_reg, d_rdata_reg;
  logic          if_valid_reg, d_valid_reg;
  logic          err_reg;

  logic          grant_d, grant_i, busy, timeout, finish;
  logic [31:0]   resp_data;

  always_comb begin
    // Fetch only beats a pending data request once the streak is exhausted.
    grant_d   = d_req && !(if_req && (streak_reg == SW'(MAX_STREAK)));
    grant_i   = if_req && !grant_d;
    busy      = (state_reg != IDLE);
    timeout   = busy && !mem_ready && (timer_reg == TW'(TIMEOUT - 1));
    finish    = busy && (mem_ready || timeout);
    resp_data = timeout ? 32'hDEADBEEF : (we_reg ? 32'h0 : mem_rdata);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_reg   <= '0;
      timer_reg    <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      dmtype_reg   <= 3'b000;
      if_rdata_reg <= 32'h0;
      d_rdata_reg  <= 32'h0;
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      if (!busy) begin
        timer_reg <= '0;
        if (grant_d) begin
          we_reg     <= d_we;
          addr_reg   <= d_addr;
          wdata_reg  <= d_wdata;
          dmtype_reg <= d_dmtype;
          if (!if_req) begin
            streak_reg <= '0;
          end else if (streak_reg != SW'(MAX_STREAK)) begin
            streak_reg <= streak_reg + SW'(1);
          end
        end else if (grant_i) begin
          we_reg     <= 1'b0;
          addr_reg   <= if_addr;
          wdata_reg  <= 32'h0;
          dmtype_reg <= 3'b000;
          streak_reg <= '0;
        end
      end else if (finish) begin
        if (state_reg == BUSY_I) begin
          if_rdata_reg <= resp_data;
          if_valid_reg <= 1'b1;
        end else begin
          d_rdata_reg <= resp_data;
          d_valid_reg <= 1'b1;
        end
        if (timeout) begin
          err_reg <= 1'b1;
        end
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

  // Memory-side fields are only exposed while an access is in flight.
  always_comb begin
    mem_req    = busy;
    mem_we     = busy && we_reg;
    mem_addr   = busy ? addr_reg : 32'h0;
    mem_wdata  = busy ? wdata_reg : 32'h0;
    mem_dmtype = busy ? dmtype_reg : 3'b000;
    if_rdata   = if_rdata_reg;
    d_rdata    = d_rdata_reg;
    if_valid   = if_valid_reg;
    d_valid    = d_valid_reg;
    err        = err_reg;
    if_stall   = if_req && !if_valid_reg;
    d_stall    = d_req && !d_valid_reg;
  end

endmodule
